// File: rtl/imem_line_responder_pkg.sv
// Shared types for the I-cache fill responder.
// Holds the line geometry, FSM states and request kinds.
package imem_line_responder_pkg;

  localparam int LINE_WORDS = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_XFER,
    S_DONE,
    S_WRITE
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_LINE,
    REQ_WORD,
    REQ_WRITE
  } req_t;

  function automatic logic [2:0] beats_for(req_t r);
    return (r == REQ_LINE) ? 3'(LINE_WORDS) : 3'd1;
  endfunction

endpackage

// File: rtl/imem_line_responder_if.sv
// Fill-port and load-port bundle between the I-cache
// (or a bench) and the memory-side responder.
interface imem_line_responder_if #(
  parameter int ADDR_WIDTH = 16
) ();

  logic [ADDR_WIDTH+1:0] I_Address;
  logic                  I_ReadLine;
  logic                  I_ReadWord;
  logic [31:0]           I_DataOut;
  logic [1:0]            I_DataOutOffset;
  logic                  I_Ready;
  logic [ADDR_WIDTH+1:0] W_Address;
  logic [31:0]           W_Data;
  logic                  W_Enable;
  logic                  W_Ready;

  modport master (
    output I_Address, I_ReadLine, I_ReadWord,
    output W_Address, W_Data, W_Enable,
    input  I_DataOut, I_DataOutOffset, I_Ready,
    input  W_Ready
  );

  modport slave (
    input  I_Address, I_ReadLine, I_ReadWord,
    input  W_Address, W_Data, W_Enable,
    output I_DataOut, I_DataOutOffset, I_Ready,
    output W_Ready
  );

endinterface

// File: rtl/imem_line_responder_word_ram.sv
// Single-port word RAM, synchronous read, no reset.
// Read data holds until the next read.
module imem_line_responder_word_ram #(
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/imem_line_responder.sv
// Memory-side responder for the I-cache fill port:
// line/word reads, critical word first, plus a load port.
module imem_line_responder
  import imem_line_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 4
) (
  input logic clock,
  input logic reset,
  imem_line_responder_if.slave bus
);

  localparam int AW = ADDR_WIDTH + 2;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] line_q, line_d;
  logic [1:0]            rd_off_q, rd_off_d;
  logic [1:0]            out_off_q, out_off_d;
  logic [2:0]            beats_q, beats_d;
  logic [3:0]            lat_q, lat_d;
  logic                  rdy_q, rdy_d;
  logic                  wrdy_q, wrdy_d;
  logic                  blank_q, blank_d;

  logic                  fetch;
  logic                  ram_we;
  logic [AW-1:0]         ram_addr;
  logic [31:0]           ram_rdata;
  req_t                  req;

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    rd_off_d  = rd_off_q;
    out_off_d = out_off_q;
    beats_d   = beats_q;
    lat_d     = lat_q;
    rdy_d     = 1'b0;
    wrdy_d    = 1'b0;
    blank_d   = blank_q;
    fetch     = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = {line_q, rd_off_q};
    req       = REQ_NONE;

    if (bus.I_ReadLine) begin
      req = REQ_LINE;
    end else if (bus.I_ReadWord) begin
      req = REQ_WORD;
    end else if (bus.W_Enable) begin
      req = REQ_WRITE;
    end

    unique case (state_q)
      S_IDLE: begin
        if (req == REQ_WRITE) begin
          ram_we   = 1'b1;
          ram_addr = bus.W_Address;
          wrdy_d   = 1'b1;
          state_d  = S_WRITE;
        end else if (req != REQ_NONE) begin
          line_d   = bus.I_Address[AW-1:2];
          rd_off_d = bus.I_Address[1:0];
          beats_d  = beats_for(req);
          lat_d    = 4'(LATENCY - 1);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_q == 4'd0) begin
          fetch   = 1'b1;
          state_d = S_XFER;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      S_XFER: begin
        if (beats_q == 3'd0) begin
          state_d = S_DONE;
        end else begin
          fetch = 1'b1;
        end
      end
      S_DONE, S_WRITE: state_d = S_IDLE;
      default:         state_d = S_IDLE;
    endcase

    // RAM read lands next cycle, together with its Ready pulse
    if (fetch) begin
      rdy_d     = 1'b1;
      out_off_d = rd_off_q;
      rd_off_d  = rd_off_q + 2'd1;
      beats_d   = beats_q - 3'd1;
      blank_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      line_q    <= '0;
      rd_off_q  <= '0;
      out_off_q <= '0;
      beats_q   <= '0;
      lat_q     <= '0;
      rdy_q     <= 1'b0;
      wrdy_q    <= 1'b0;
      blank_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      rd_off_q  <= rd_off_d;
      out_off_q <= out_off_d;
      beats_q   <= beats_d;
      lat_q     <= lat_d;
      rdy_q     <= rdy_d;
      wrdy_q    <= wrdy_d;
      blank_q   <= blank_d;
    end
  end

  imem_line_responder_word_ram #(
    .AW (AW)
  ) u_ram (
    .clk   (clock),
    .we    (ram_we),
    .re    (fetch),
    .addr  (ram_addr),
    .wdata (bus.W_Data),
    .rdata (ram_rdata)
  );

  // RAM output register has no reset; mask it until the first beat
  assign bus.I_DataOut       = blank_q ? 32'd0 : ram_rdata;
  assign bus.I_DataOutOffset = out_off_q;
  assign bus.I_Ready         = rdy_q;
  assign bus.W_Ready         = wrdy_q;

endmodule
